// File: rtl/conv_sweep_scheduler_if.sv
// Result record channel from the sweep scheduler to a collector/checker.
// One record per swept code, transferred on res_valid && res_ready.
//   res_valid  : record valid (driven by the scheduler)
//   res_ready  : collector ready (driven by the collector)
//   res_code   : converter input code the record belongs to
//   res_value  : last sampled converter output for that code
//   res_stable : 1 = output settled, 0 = timed out
interface conv_sweep_scheduler_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) ();
    logic             res_valid;
    logic             res_ready;
    logic [IN_W-1:0]  res_code;
    logic [OUT_W-1:0] res_value;
    logic             res_stable;

    modport master (
        output res_valid,
        input  res_ready,
        output res_code,
        output res_value,
        output res_stable
    );

    modport slave (
        input  res_valid,
        output res_ready,
        input  res_code,
        input  res_value,
        input  res_stable
    );
endinterface

// File: rtl/conv_sweep_scheduler.sv
// Sweeps one shared fixed-to-float converter through a programmed list of
// input codes. For each code the converter is held in reset, released, its
// output sampled on a slow prescaled tick until it either repeats for
// STABLE_CNT consecutive comparisons (stable) or TIMEOUT samples elapse
// (unstable), and one result record is emitted on the res channel.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : one-cycle sweep request, ignored while busy
//   code_base/step/count: sweep configuration, latched on accepted start
//   busy, done          : sweep in progress / one-cycle end-of-sweep pulse
//   conv_rst_n, conv_in : converter reset and input code
//   conv_out            : converter result
//   res                 : result record channel (master side)
//   fail_count          : unstable codes in the current or last sweep
module conv_sweep_scheduler #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 32,
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 20,
    parameter int TIMEOUT    = 400,
    parameter int RST_CYCLES = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [IN_W-1:0]        code_base,
    input  logic [IN_W-1:0]        code_step,
    input  logic [9:0]             code_count,
    output logic                   busy,
    output logic                   done,
    output logic                   conv_rst_n,
    output logic [IN_W-1:0]        conv_in,
    input  logic [OUT_W-1:0]       conv_out,
    conv_sweep_scheduler_if.master res,
    output logic [9:0]             fail_count
);
    localparam int PS_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SC_W = $clog2(TIMEOUT + 1);
    localparam int MC_W = $clog2(STABLE_CNT + 1);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRST   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_REPORT = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nx;

    logic [IN_W-1:0]   step_r;
    logic [9:0]        cnt_r;
    logic [9:0]        idx_r;
    logic [IN_W-1:0]   code_r;
    logic [RC_W-1:0]   rst_cnt_r;
    logic [PS_W-1:0]   ps_r;
    logic [SC_W-1:0]   smp_cnt_r;
    logic [MC_W-1:0]   match_cnt_r;
    logic [OUT_W-1:0]  prev_r;
    logic              prev_vld_r;
    logic [9:0]        fail_cnt_r;

    logic              busy_r;
    logic              done_r;
    logic              conv_rst_n_r;
    logic              res_valid_r;
    logic [IN_W-1:0]   res_code_r;
    logic [OUT_W-1:0]  res_value_r;
    logic              res_stable_r;

    logic              tick_s;
    logic              rst_done_s;
    logic [MC_W-1:0]   match_nx_s;
    logic [SC_W-1:0]   smp_nx_s;
    logic              stable_s;
    logic              timeout_s;
    logic              hs_s;
    logic              last_s;

    // Next-state and per-cycle decision logic.
    always_comb begin
        state_nx   = state_r;
        tick_s     = (ps_r == PS_W'(SAMPLE_DIV - 1));
        rst_done_s = (rst_cnt_r == RC_W'(RST_CYCLES - 1));
        smp_nx_s   = smp_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
        if (prev_vld_r && (conv_out == prev_r)) begin
            match_nx_s = match_cnt_r + {{(MC_W-1){1'b0}}, 1'b1};
        end else begin
            match_nx_s = {MC_W{1'b0}};
        end
        // Stable takes priority when both limits are reached on one tick.
        stable_s  = tick_s && (match_nx_s == MC_W'(STABLE_CNT));
        timeout_s = tick_s && (smp_nx_s == SC_W'(TIMEOUT)) && !stable_s;
        hs_s      = res_valid_r && res.res_ready;
        last_s    = (idx_r == (cnt_r - 10'd1));

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (code_count == 10'd0) begin
                        state_nx = ST_FIN;
                    end else begin
                        state_nx = ST_CRST;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CRST: begin
                if (rst_done_s) begin
                    state_nx = ST_SETTLE;
                end else begin
                    state_nx = ST_CRST;
                end
            end
            ST_SETTLE: begin
                if (stable_s || timeout_s) begin
                    state_nx = ST_REPORT;
                end else begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_REPORT: begin
                if (hs_s) begin
                    if (last_s) begin
                        state_nx = ST_FIN;
                    end else begin
                        state_nx = ST_CRST;
                    end
                end else begin
                    state_nx = ST_REPORT;
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Sweep datapath: configuration, code walk, reset timer and stability sampler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_r       <= {IN_W{1'b0}};
            cnt_r        <= 10'd0;
            idx_r        <= 10'd0;
            code_r       <= {IN_W{1'b0}};
            rst_cnt_r    <= {RC_W{1'b0}};
            ps_r         <= {PS_W{1'b0}};
            smp_cnt_r    <= {SC_W{1'b0}};
            match_cnt_r  <= {MC_W{1'b0}};
            prev_r       <= {OUT_W{1'b0}};
            prev_vld_r   <= 1'b0;
            fail_cnt_r   <= 10'd0;
            res_code_r   <= {IN_W{1'b0}};
            res_value_r  <= {OUT_W{1'b0}};
            res_stable_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        step_r     <= code_step;
                        cnt_r      <= code_count;
                        idx_r      <= 10'd0;
                        code_r     <= code_base;
                        fail_cnt_r <= 10'd0;
                        rst_cnt_r  <= {RC_W{1'b0}};
                    end
                end
                ST_CRST: begin
                    rst_cnt_r <= rst_cnt_r + {{(RC_W-1){1'b0}}, 1'b1};
                    if (rst_done_s) begin
                        ps_r        <= {PS_W{1'b0}};
                        smp_cnt_r   <= {SC_W{1'b0}};
                        match_cnt_r <= {MC_W{1'b0}};
                        prev_vld_r  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (tick_s) begin
                        ps_r        <= {PS_W{1'b0}};
                        smp_cnt_r   <= smp_nx_s;
                        match_cnt_r <= match_nx_s;
                        prev_r      <= conv_out;
                        prev_vld_r  <= 1'b1;
                    end else begin
                        ps_r <= ps_r + {{(PS_W-1){1'b0}}, 1'b1};
                    end
                    // Capture the record payload on the deciding tick.
                    if (stable_s || timeout_s) begin
                        res_code_r   <= code_r;
                        res_value_r  <= conv_out;
                        res_stable_r <= stable_s;
                    end
                    if (timeout_s) begin
                        fail_cnt_r <= fail_cnt_r + 10'd1;
                    end
                end
                ST_REPORT: begin
                    if (hs_s && !last_s) begin
                        code_r    <= code_r + step_r;
                        idx_r     <= idx_r + 10'd1;
                        rst_cnt_r <= {RC_W{1'b0}};
                    end
                end
                ST_FIN: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            conv_rst_n_r <= 1'b0;
            res_valid_r  <= 1'b0;
        end else begin
            busy_r       <= (state_nx != ST_IDLE);
            done_r       <= (state_nx == ST_FIN);
            conv_rst_n_r <= (state_nx == ST_SETTLE) || (state_nx == ST_REPORT);
            res_valid_r  <= (state_nx == ST_REPORT);
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign conv_rst_n     = conv_rst_n_r;
    assign conv_in        = code_r;
    assign fail_count     = fail_cnt_r;
    assign res.res_valid  = res_valid_r;
    assign res.res_code   = res_code_r;
    assign res.res_value  = res_value_r;
    assign res.res_stable = res_stable_r;
endmodule

// File: tb/tb_conv_sweep_scheduler.sv
// Directed bench for conv_sweep_scheduler with a behavioural converter stub.
module tb_conv_sweep_scheduler;
    localparam logic [31:0] ONE_F = 32'h3F800000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] code_base = 16'h0000;
    logic [15:0] code_step = 16'h0000;
    logic [9:0]  code_count = 10'd0;
    logic        busy;
    logic        done;
    logic        conv_rst_n;
    logic [15:0] conv_in;
    logic [31:0] conv_out;
    logic [9:0]  fail_count;

    logic        toggle_mode = 1'b0;
    logic [31:0] stub_val = ONE_F;
    logic [31:0] tog_val = 32'h0;
    logic [1:0]  tog_div = 2'd0;

    int total = 0;
    int bad = 0;
    int rec_cnt = 0;

    conv_sweep_scheduler_if #(.IN_W(16), .OUT_W(32)) res_if ();

    conv_sweep_scheduler #(
        .IN_W(16), .OUT_W(32), .SAMPLE_DIV(4), .STABLE_CNT(3),
        .TIMEOUT(10), .RST_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .code_base(code_base),
        .code_step(code_step),
        .code_count(code_count),
        .busy(busy),
        .done(done),
        .conv_rst_n(conv_rst_n),
        .conv_in(conv_in),
        .conv_out(conv_out),
        .res(res_if),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Toggling stub output changes exactly every 4 clocks (one sample period).
    always @(posedge clk) begin
        tog_div <= tog_div + 2'd1;
        if (tog_div == 2'd3) tog_val <= (tog_val == 32'h0) ? ONE_F : 32'h0;
    end
    assign conv_out = toggle_mode ? tog_val : stub_val;

    always @(posedge clk) begin
        if (reset_n && res_if.res_valid && res_if.res_ready) rec_cnt <= rec_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive an accepted start; returns positioned at cycle 1 (first CRST cycle).
    task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [9:0] c);
        code_base  = b;
        code_step  = s;
        code_count = c;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_valid(output int n, input int limit);
        n = 0;
        while (!res_if.res_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    // From the first CRST cycle of a code to its (stable) record being valid.
    task automatic to_report(input logic [15:0] code, input logic [31:0] val);
        int n;
        chk("crst1_rstn", conv_rst_n, 1'b0);
        chk("crst1_in", conv_in, code);
        chk("crst1_busy", busy, 1'b1);
        step();
        chk("crst2_rstn", conv_rst_n, 1'b0);
        step();
        chk("settle_rstn", conv_rst_n, 1'b1);
        chk("settle_valid", res_if.res_valid, 1'b0);
        wait_valid(n, 100);
        chk("stable_latency", n, 16);
        chk("res_code", res_if.res_code, code);
        chk("res_value", res_if.res_value, val);
        chk("res_stable", res_if.res_stable, 1'b1);
    endtask

    initial begin
        int n;
        int snap;
        int seen;
        res_if.res_ready = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_conv_rst_n", conv_rst_n, 1'b0);
        chk("rst_conv_in", conv_in, 16'h0);
        chk("rst_valid", res_if.res_valid, 1'b0);
        chk("rst_stable", res_if.res_stable, 1'b0);
        chk("rst_code", res_if.res_code, 16'h0);
        chk("rst_value", res_if.res_value, 32'h0);
        chk("rst_fail", fail_count, 10'd0);
        reset_n = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);

        // Stable single code
        do_start(16'h2000, 16'h0001, 10'd1);
        to_report(16'h2000, ONE_F);
        step();
        chk("t1_done", done, 1'b1);
        chk("t1_valid_drop", res_if.res_valid, 1'b0);
        chk("t1_fail", fail_count, 10'd0);
        step();
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_busy_drop", busy, 1'b0);

        // Toggling output times out
        toggle_mode = 1'b1;
        do_start(16'h1234, 16'h0001, 10'd1);
        step();
        step();
        chk("t2_settle_rstn", conv_rst_n, 1'b1);
        wait_valid(n, 100);
        chk("t2_timeout_latency", n, 40);
        chk("t2_stable", res_if.res_stable, 1'b0);
        chk("t2_code", res_if.res_code, 16'h1234);
        chk("t2_fail", fail_count, 10'd1);
        step();
        chk("t2_done", done, 1'b1);
        step();
        chk("t2_fail_hold", fail_count, 10'd1);
        toggle_mode = 1'b0;

        // Wrap and re-reset
        snap = rec_cnt;
        do_start(16'hFFFF, 16'h0001, 10'd3);
        chk("t3_fail_clear", fail_count, 10'd0);
        to_report(16'hFFFF, ONE_F);
        step();
        to_report(16'h0000, ONE_F);
        step();
        to_report(16'h0001, ONE_F);
        step();
        chk("t3_done", done, 1'b1);
        chk("t3_records", rec_cnt - snap, 3);

        // Backpressure
        step();
        res_if.res_ready = 1'b0;
        do_start(16'h0100, 16'h0010, 10'd2);
        to_report(16'h0100, ONE_F);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", res_if.res_valid, 1'b1);
            chk("bp_code", res_if.res_code, 16'h0100);
            chk("bp_value", res_if.res_value, ONE_F);
            chk("bp_conv_in", conv_in, 16'h0100);
        end
        res_if.res_ready = 1'b1;
        step();
        chk("bp_next_valid", res_if.res_valid, 1'b0);
        to_report(16'h0110, ONE_F);
        step();
        chk("bp_done", done, 1'b1);
        step();

        // Reset mid-SETTLE
        do_start(16'h0AAA, 16'h0001, 10'd1);
        for (int i = 0; i < 7; i++) step();
        chk("mid_in_settle", conv_rst_n, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_rstn", conv_rst_n, 1'b0);
        chk("mid_conv_in", conv_in, 16'h0);
        chk("mid_valid", res_if.res_valid, 1'b0);
        chk("mid_fail", fail_count, 10'd0);
        step();
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done || res_if.res_valid || busy) seen++;
        end
        chk("mid_quiet", seen, 0);
        do_start(16'h0555, 16'h0001, 10'd1);
        to_report(16'h0555, ONE_F);
        step();
        chk("mid_restart_done", done, 1'b1);
        step();

        // Zero count
        snap = rec_cnt;
        do_start(16'h4444, 16'h0001, 10'd0);
        chk("z_done", done, 1'b1);
        chk("z_busy", busy, 1'b1);
        chk("z_valid", res_if.res_valid, 1'b0);
        step();
        chk("z_done_pulse", done, 1'b0);
        chk("z_busy_drop", busy, 1'b0);
        chk("z_records", rec_cnt - snap, 0);

        // Start while busy is ignored
        snap = rec_cnt;
        res_if.res_ready = 1'b0;
        do_start(16'h0300, 16'h0002, 10'd2);
        to_report(16'h0300, ONE_F);
        code_base  = 16'h7777;
        code_step  = 16'h0005;
        code_count = 10'd9;
        start      = 1'b1;
        step();
        start      = 1'b0;
        chk("ig_code_hold", res_if.res_code, 16'h0300);
        chk("ig_valid_hold", res_if.res_valid, 1'b1);
        res_if.res_ready = 1'b1;
        step();
        to_report(16'h0302, ONE_F);
        step();
        chk("ig_done", done, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("ig_idle", busy, 1'b0);
        chk("ig_records", rec_cnt - snap, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_sweep_scheduler.md
# conv_sweep_scheduler

Sequencer that drives one shared fixed-to-float converter instance (16-bit input code, 32-bit IEEE 754 output) through a programmed sweep of input codes. For each code it resets the converter, waits for the output to settle, checks stability over a sampled window and emits one result record over a valid/ready handshake. It replaces per-code converter replication: one converter, one scheduler, results streamed to a collector or checker.

## Interface
- `IN_W`, 16: converter input code width.
- `OUT_W`, 32: converter output width.
- `SAMPLE_DIV`, 1000: `clk` cycles per stability sample tick (100 MHz to 100 kHz).
- `STABLE_CNT`, 20: consecutive equal sample comparisons required to declare stable.
- `TIMEOUT`, 400: maximum sample ticks per code before declaring unstable.
- `RST_CYCLES`, 10: `clk` cycles `conv_rst_n` is held low per code.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a sweep; ignored while `busy`.
- `code_base`, in, IN_W: first code; sampled on an accepted `start`.
- `code_step`, in, IN_W: code increment; sampled on an accepted `start`.
- `code_count`, in, 10: number of codes; sampled on an accepted `start`.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at sweep end.
- `conv_rst_n`, out, 1: reset to the converter, active-low.
- `conv_in`, out, IN_W: current code to the converter.
- `conv_out`, in, OUT_W: converter result.
- `res_valid`, out, 1: result record valid.
- `res_ready`, in, 1: result consumer ready.
- `res_code`, out, IN_W: code of the record.
- `res_value`, out, OUT_W: last sampled `conv_out`.
- `res_stable`, out, 1: 1 = stable, 0 = timed out.
- `fail_count`, out, 10: unstable codes in the current or last sweep.

## Operation
- States: IDLE, CRST, SETTLE, REPORT, FIN.
- IDLE: `conv_rst_n`=0. On `start`, latch the configuration, set code=`code_base`, idx=0 and clear `fail_count`. If `code_count`==0, go to FIN; otherwise go to CRST.
- CRST: `conv_rst_n`=0 for RST_CYCLES cycles while `conv_in`=code. Then clear the prescaler, sample count, match count and the prev-valid flag, and go to SETTLE.
- SETTLE: `conv_rst_n`=1. The prescaler counts 0..SAMPLE_DIV-1; tick = (prescaler==SAMPLE_DIV-1). On each tick:
  - sample_cnt increments.
  - If prev valid and `conv_out`==prev, match_cnt increments; otherwise match_cnt is cleared.
  - prev is loaded with `conv_out` and prev-valid is set.
- SETTLE exit, stable: match_cnt reaches STABLE_CNT. Go to REPORT with `res_stable`=1.
- SETTLE exit, timeout: sample_cnt reaches TIMEOUT without the stable condition. Go to REPORT with `res_stable`=0 and increment `fail_count`.
- Stable wins if both exit conditions occur on the same tick.
- REPORT: `res_valid`=1; payload is held constant until `res_valid`&&`res_ready`. On handshake:
  - If idx==code_count-1, go to FIN.
  - Otherwise code += code_step (modulo 2^IN_W, wraps silently), idx++, and go to CRST.
- FIN: `done`=1 for one cycle, then go to IDLE. `busy` drops in the same cycle as the FIN-to-IDLE transition.
- `fail_count` holds its value after the sweep until the next accepted `start`.

## Timing
- Reset values (asynchronous assert, deassert registered on `clk`):
  - State is IDLE.
  - `busy`, `done`, `res_valid`, `res_stable` and `conv_rst_n` are 0.
  - `conv_in`, `res_code`, `res_value` and `fail_count` are 0.
- Reset mid-sweep: immediate abort with all outputs at reset values. No partial record is emitted and no `done` pulse is generated.
- `start` sampled at cycle 0:
  - `busy`=1 and CRST at cycle 1; `conv_rst_n` low for cycles 1..RST_CYCLES.
  - SETTLE from cycle RST_CYCLES+1.
  - First tick at SETTLE entry + SAMPLE_DIV - 1.
- Minimum stable decision is at tick STABLE_CNT+1. `res_valid` rises the cycle after the deciding tick.
- Handshake in cycle t: CRST (or FIN) at t+1; `res_valid`=0 at t+1.
- `done` is asserted the cycle after the last handshake. With `code_count`==0, `done` is asserted 1 cycle after the `start` is accepted.
- `start` while busy: no effect on configuration, state or `fail_count`.

## Test plan
Bench parameters: SAMPLE_DIV=4, STABLE_CNT=3, TIMEOUT=10, RST_CYCLES=2; the converter is a behavioural stub.
- **Stable single code.** Stimulus: base=0x2000, count=1, `res_ready`=1, stub `conv_out`=0x3F800000. Required: `conv_rst_n` low for exactly 2 cycles; `res_valid` at SETTLE entry+16; `res_code`=0x2000, `res_value`=0x3F800000, `res_stable`=1; `done` 1 cycle later; `fail_count`=0.
- **Toggling output.** Stimulus: `conv_out` alternates 0x00000000/0x3F800000 every tick. Required: record after 10 ticks with `res_stable`=0; `fail_count`=1.
- **Wrap and re-reset.** Stimulus: base=0xFFFF, step=1, count=3. Required: records with codes 0xFFFF, 0x0000, 0x0001 in order; a 2-cycle `conv_rst_n` low pulse precedes each code.
- **Backpressure.** Stimulus: hold `res_ready`=0 for 5 cycles in REPORT. Required: `res_valid` and payload stable throughout; `conv_in` does not advance; the next code begins 1 cycle after ready rises.
- **Reset mid-SETTLE.** Stimulus: pulse `reset_n` low during SETTLE. Required: outputs reach reset values asynchronously and no `done` pulse is seen; a following `start` runs a normal sweep.
- **Zero count and ignored start.** Stimulus: `code_count`=0, then a second `start` pulsed while busy during a 2-code sweep. Required: for count=0, `done` 1 cycle after start with no `res_valid`; the 2-code sweep produces exactly 2 records with the original configuration.
